// File: rtl/stream_packer_pkg.sv
// rtl/stream_packer_pkg.sv - shared constants, state encoding and helpers for the element FIFO / packer pair
//
// Contents:
//   DEFAULT_ELE_BANDWIDTH, DEFAULT_PACK_FACTOR, DEFAULT_FLUSH_TIMEOUT - default widths/limits
//   pack_state_e - packer FSM encoding (PACK_STATE_FILL / PACK_STATE_HOLD)
//   clog2()      - ceiling log2 usable in parameter expressions
package stream_packer_pkg;

    localparam int DEFAULT_ELE_BANDWIDTH = 8;
    localparam int DEFAULT_PACK_FACTOR   = 4;
    localparam int DEFAULT_FLUSH_TIMEOUT = 16;

    typedef enum logic {
        PACK_STATE_FILL = 1'b0,
        PACK_STATE_HOLD = 1'b1
    } pack_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_packer_if.sv
// rtl/stream_packer_if.sv - element-in / packed-word-out handshake bundle for stream_packer
//
// Signals:
//   i_valid, i_push_data, i_last, o_ready       - element stream into the packer
//   o_valid, o_pack_data, o_keep, o_last, i_ready - packed word stream out of the packer
// Modports:
//   slave  - the packer side
//   master - the side that feeds elements and drains words
interface stream_packer_if
    import stream_packer_pkg::*;
#(
    parameter int ELE_BANDWIDTH = DEFAULT_ELE_BANDWIDTH,
    parameter int PACK_FACTOR   = DEFAULT_PACK_FACTOR
);

    logic                                 i_valid;
    logic [ELE_BANDWIDTH-1:0]             i_push_data;
    logic                                 i_last;
    logic                                 o_ready;
    logic                                 o_valid;
    logic [ELE_BANDWIDTH*PACK_FACTOR-1:0] o_pack_data;
    logic [PACK_FACTOR-1:0]               o_keep;
    logic                                 o_last;
    logic                                 i_ready;

    modport slave (
        input  i_valid, i_push_data, i_last, i_ready,
        output o_ready, o_valid, o_pack_data, o_keep, o_last
    );

    modport master (
        output i_valid, i_push_data, i_last, i_ready,
        input  o_ready, o_valid, o_pack_data, o_keep, o_last
    );

endinterface

// File: rtl/stream_packer_pack_out_reg.sv
// rtl/stream_packer_pack_out_reg.sv - single-slot valid/ready output register for packed words
//
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_load                    - capture i_data/i_keep/i_last this edge
//   i_data, i_keep, i_last    - word to capture
//   i_ready                   - downstream accepts the presented word
//   o_valid, o_data, o_keep, o_last - presented word
//   o_free                    - slot can take a new word on this edge
module pack_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last,
    output logic              o_free
);

    // Free when empty or when the current word leaves on this same edge.
    assign o_free = !o_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_keep  <= i_keep;
            o_last  <= i_last;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs PACK_FACTOR consecutive elements into one wide word with keep/last
//
// Ports:
//   i_clk - clock, rising edge
//   i_rst - synchronous active-high reset
//   bus   - stream_packer_if.slave: element stream in, packed word stream out
// Build option:
//   PACKER_FLUSH_TIMEOUT_EN - when defined, a partial word is flushed (o_last=0)
//   after FLUSH_TIMEOUT idle cycles; when undefined no idle counter exists.
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int ELE_BANDWIDTH = DEFAULT_ELE_BANDWIDTH,
`ifdef PACKER_FLUSH_TIMEOUT_EN
    parameter int FLUSH_TIMEOUT = DEFAULT_FLUSH_TIMEOUT,
`endif
    parameter int PACK_FACTOR   = DEFAULT_PACK_FACTOR
) (
    input  logic           i_clk,
    input  logic           i_rst,
    stream_packer_if.slave bus
);

    localparam int LANE_W = clog2(PACK_FACTOR);
    localparam int CNT_W  = LANE_W + 1;
    localparam int WORD_W = ELE_BANDWIDTH * PACK_FACTOR;

    pack_state_e            state, state_nxt;

    logic [WORD_W-1:0]      acc_data;
    logic [PACK_FACTOR-1:0] acc_keep;
    logic [CNT_W-1:0]       acc_count;
    logic                   acc_last;

    logic                   accept;
    logic                   last_lane;
    logic                   flush_timeout;
    logic                   complete;
    logic                   out_free;
    logic                   out_load;
    logic                   acc_clear;
    logic                   acc_store;
    logic                   cnt_inc;

    logic [WORD_W-1:0]      word_data;
    logic [PACK_FACTOR-1:0] word_keep;
    logic                   word_last;

    // o_ready depends on state only, so there is no path from i_valid.
    assign bus.o_ready = (state == PACK_STATE_FILL);
    assign accept      = bus.i_valid && (state == PACK_STATE_FILL);
    assign last_lane   = (acc_count == CNT_W'(PACK_FACTOR - 1));

    // Accumulator contents with the element being accepted merged into its lane,
    // so a completing word can go straight to the output register this edge.
    always_comb begin
        word_data = acc_data;
        word_keep = acc_keep;
        for (int k = 0; k < PACK_FACTOR; k++) begin
            if (accept && (acc_count == CNT_W'(k))) begin
                word_data[k*ELE_BANDWIDTH +: ELE_BANDWIDTH] = bus.i_push_data;
                word_keep[k] = 1'b1;
            end
        end
    end

`ifdef PACKER_FLUSH_TIMEOUT_EN
    localparam int IDLE_W = clog2(FLUSH_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_count;
    logic              idle_armed;

    // Only a partially filled word in FILL ages; anything else restarts the count.
    assign idle_armed    = (state == PACK_STATE_FILL) && (acc_count != '0);
    assign flush_timeout = idle_armed && !accept &&
                           (idle_count == IDLE_W'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || accept || !idle_armed || flush_timeout) begin
            idle_count <= '0;
        end else begin
            idle_count <= idle_count + IDLE_W'(1);
        end
    end
`else
    assign flush_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= PACK_STATE_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        word_last = acc_last;
        out_load  = 1'b0;
        acc_clear = 1'b0;
        acc_store = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            PACK_STATE_FILL: begin
                complete  = (accept && (last_lane || bus.i_last)) || flush_timeout;
                // A timeout flush is not an accepted element, so it never closes a group.
                word_last = accept && bus.i_last;
                if (complete) begin
                    if (out_free) begin
                        out_load  = 1'b1;
                        acc_clear = 1'b1;
                    end else begin
                        acc_store = 1'b1;
                        state_nxt = PACK_STATE_HOLD;
                    end
                end else if (accept) begin
                    acc_store = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            PACK_STATE_HOLD: begin
                if (out_free) begin
                    out_load  = 1'b1;
                    acc_clear = 1'b1;
                    state_nxt = PACK_STATE_FILL;
                end
            end
            default: begin
                state_nxt = PACK_STATE_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || acc_clear) begin
            acc_data  <= '0;
            acc_keep  <= '0;
            acc_count <= '0;
            acc_last  <= 1'b0;
        end else begin
            if (acc_store) begin
                acc_data <= word_data;
                acc_keep <= word_keep;
                acc_last <= word_last;
            end
            if (cnt_inc) begin
                acc_count <= acc_count + CNT_W'(1);
            end
        end
    end

    pack_out_reg #(
        .DATA_W (WORD_W),
        .KEEP_W (PACK_FACTOR)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (out_load),
        .i_data  (word_data),
        .i_keep  (word_keep),
        .i_last  (word_last),
        .i_ready (bus.i_ready),
        .o_valid (bus.o_valid),
        .o_data  (bus.o_pack_data),
        .o_keep  (bus.o_keep),
        .o_last  (bus.o_last),
        .o_free  (out_free)
    );

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - self-checking bench for stream_packer (ELE=8, PACK=4)
module tb_stream_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_packer_if #(.ELE_BANDWIDTH(8), .PACK_FACTOR(4)) bus ();

    stream_packer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    last_hs = 0;
    int    prev_hs = 0;
    bit    sb_en = 1'b1;
    word_t exp_q[$];
    logic [31:0] cur_data = '0;
    int    cur_n = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: elements gathered into a list; a word is emitted when
    // four are collected or the element carries last. Words leave in order.
    always @(negedge clk) begin
        word_t w;
        word_t nw;
        if (rst) begin
            exp_q.delete();
            cur_n    = 0;
            cur_data = '0;
        end else if (sb_en) begin
            if (bus.o_valid && bus.i_ready) begin
                hs_count++;
                prev_hs = last_hs;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 64'(bus.o_pack_data), 64'hDEAD);
                end else begin
                    w = exp_q.pop_front();
                    check("sb_data", 64'(bus.o_pack_data), 64'(w.data));
                    check("sb_keep", 64'(bus.o_keep), 64'(w.keep));
                    check("sb_last", 64'(bus.o_last), 64'(w.last));
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                cur_data[cur_n*8 +: 8] = bus.i_push_data;
                cur_n++;
                if (bus.i_last || cur_n == 4) begin
                    nw.data = cur_data;
                    nw.keep = 4'((1 << cur_n) - 1);
                    nw.last = bus.i_last;
                    exp_q.push_back(nw);
                    cur_n    = 0;
                    cur_data = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until the packer takes it.
    task automatic push(input logic [7:0] d, input logic l, output int waited);
        bus.i_valid     = 1'b1;
        bus.i_push_data = d;
        bus.i_last      = l;
        waited = 0;
        @(negedge clk);
        while (!bus.o_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) check("push_timeout", 64'(waited), 64'd0);
        tick();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hs0;
        int vcount;
        logic [7:0] d;

        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_push_data = '0;
        bus.i_last      = 1'b0;
        bus.i_ready     = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_data",  64'(bus.o_pack_data), 64'd0);
        check("rst_keep",  64'(bus.o_keep), 64'd0);
        check("rst_last",  64'(bus.o_last), 64'd0);
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        tick();
        rst = 1'b0;

        // Full word, downstream always ready
        bus.i_ready = 1'b1;
        push(8'h11, 1'b0, w); check("t1_wait0", 64'(w), 64'd0);
        push(8'h22, 1'b0, w); check("t1_wait1", 64'(w), 64'd0);
        push(8'h33, 1'b0, w); check("t1_wait2", 64'(w), 64'd0);
        push(8'h44, 1'b0, w); check("t1_wait3", 64'(w), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(bus.o_valid), 64'd1);
        check("t1_data",  64'(bus.o_pack_data), 64'h44332211);
        check("t1_keep",  64'(bus.o_keep), 64'hF);
        check("t1_last",  64'(bus.o_last), 64'd0);
        tick();

        // Partial word closed by last
        push(8'hAA, 1'b0, w);
        push(8'hBB, 1'b1, w);
        @(negedge clk);
        check("t2_data", 64'(bus.o_pack_data), 64'h0000BBAA);
        check("t2_keep", 64'(bus.o_keep), 64'h3);
        check("t2_last", 64'(bus.o_last), 64'd1);
        tick();

        // last on lane 0, last on the final lane
        push(8'h99, 1'b1, w);
        @(negedge clk);
        check("b_lane0_data", 64'(bus.o_pack_data), 64'h99);
        check("b_lane0_keep", 64'(bus.o_keep), 64'h1);
        check("b_lane0_last", 64'(bus.o_last), 64'd1);
        tick();
        push(8'hC1, 1'b0, w);
        push(8'hC2, 1'b0, w);
        push(8'hC3, 1'b0, w);
        push(8'hC4, 1'b1, w);
        @(negedge clk);
        check("b_lane3_data", 64'(bus.o_pack_data), 64'hC4C3C2C1);
        check("b_lane3_keep", 64'(bus.o_keep), 64'hF);
        check("b_lane3_last", 64'(bus.o_last), 64'd1);
        tick();

`ifndef PACKER_FLUSH_TIMEOUT_EN
        // Without last a partial word must wait indefinitely
        push(8'h33, 1'b0, w);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_valid) vcount++;
            tick();
        end
        check("b_no_flush", 64'(vcount), 64'd0);
        push(8'h34, 1'b1, w);
        tick();
`endif

        // Backpressure: second word parks in HOLD
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b0, w);
        @(negedge clk);
        check("t3_hold_ready", 64'(bus.o_ready), 64'd0);
        check("t3_hold_valid", 64'(bus.o_valid), 64'd1);
        check("t3_hold_data",  64'(bus.o_pack_data), 64'h04030201);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("t3_stable_data",  64'(bus.o_pack_data), 64'h04030201);
        check("t3_stable_ready", 64'(bus.o_ready), 64'd0);
        tick();
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("t3_release_data", 64'(bus.o_pack_data), 64'h04030201);
        tick();
        @(negedge clk);
        check("t3_next_valid", 64'(bus.o_valid), 64'd1);
        check("t3_next_data",  64'(bus.o_pack_data), 64'h08070605);
        check("t3_next_ready", 64'(bus.o_ready), 64'd1);
        tick();

        // Reset mid-operation discards pending word and partial accumulator
        bus.i_ready = 1'b0;
        push(8'h10, 1'b0, w);
        push(8'h20, 1'b0, w);
        push(8'h30, 1'b0, w);
        push(8'h40, 1'b0, w);
        push(8'h50, 1'b0, w);
        push(8'h60, 1'b0, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", 64'(bus.o_valid), 64'd0);
        check("t4_keep",  64'(bus.o_keep), 64'd0);
        tick();
        bus.i_ready = 1'b1;
        push(8'h71, 1'b0, w);
        push(8'h72, 1'b0, w);
        push(8'h73, 1'b0, w);
        push(8'h74, 1'b0, w);
        @(negedge clk);
        check("t4_data", 64'(bus.o_pack_data), 64'h74737271);
        check("t4_keep_full", 64'(bus.o_keep), 64'hF);
        tick();

        // Continuous stream: 3 words, no stalls, 4 cycles apart
        hs0 = hs_count;
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom), 1'b0, w);
            check("t5_no_stall", 64'(w), 64'd0);
        end
        tick();
        @(negedge clk);
        check("t5_words", 64'(hs_count - hs0), 64'd3);
        check("t5_period", 64'(last_hs - prev_hs), 64'd4);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.i_valid     = ($urandom % 4) != 0;
            bus.i_push_data = 8'($urandom);
            bus.i_last      = ($urandom % 6) == 0;
            bus.i_ready     = ($urandom % 3) != 0;
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        d = 8'($urandom);
        push(d, 1'b1, w);
        repeat (10) tick();
        @(negedge clk);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_idle_valid", 64'(bus.o_valid), 64'd0);
        tick();

`ifdef PACKER_FLUSH_TIMEOUT_EN
        // Idle timeout flushes a partial word without last
        sb_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_ready = 1'b1;
        push(8'h5A, 1'b0, w);
        vcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.o_valid) vcount++;
            tick();
        end
        check("t6_early", 64'(vcount), 64'd0);
        @(negedge clk);
        check("t6_valid", 64'(bus.o_valid), 64'd1);
        check("t6_data",  64'(bus.o_pack_data), 64'h5A);
        check("t6_keep",  64'(bus.o_keep), 64'h1);
        check("t6_last",  64'(bus.o_last), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
